// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   md_op_e    : op codes carried on op_EX
//   md_state_e : FSM state encoding of ex_muldiv_unit
//   DIV0_LO    : LO value produced by a divide by zero (all ones, sliced to WIDTH)
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10
    } md_state_e;

    // Wide enough for any supported WIDTH (<= 64); users take the low WIDTH bits.
    localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/md_iter_step.sv
// One combinational iteration of the iterative multiply/divide datapath.
// The accumulator is {upper, lower}, each WIDTH bits.
//   multiply (op_is_div=0): upper = partial product, lower = remaining multiplier bits.
//     If lower[0] is set the operand is added to upper, then the whole
//     {carry, upper, lower} is shifted right by one.
//   divide   (op_is_div=1): upper = partial remainder, lower = dividend bits / quotient.
//     {upper, lower[MSB]} is trial-subtracted by the divisor (restoring divide);
//     the lower half shifts left and its lsb is left 0 for the caller to fill
//     with q_bit.
// Ports:
//   acc       in   2*WIDTH  current accumulator
//   operand   in   WIDTH    multiplicand magnitude or divisor magnitude
//   op_is_div in   1        selects divide step
//   acc_next  out  2*WIDTH  next accumulator (quotient slot = 0)
//   q_bit     out  1        next quotient bit (0 for multiply)
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               op_is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = trial - {1'b0, operand};
        acc_next = '0;
        q_bit    = 1'b0;
        if (op_is_div) begin
            // trial < 2*divisor, so bit WIDTH of the difference is a clean borrow flag.
            q_bit    = ~diff[WIDTH];
            acc_next = {(q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU/DIV/DIVU run one iteration per cycle on operand magnitudes,
// then a fix-up cycle applies signs and writes HI/LO. MTHI/MTLO write
// HI/LO directly while the unit is idle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// product and skip the iteration phase (IDLE -> FIXUP). Divide is unaffected.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start_EX, op_EX     start strobe and op code (md_op_e)
//   dr1_EX, dr2_EX      rs / rt operands
//   flush_EX            abort in-flight op / drop a start in the same cycle
//   hi_we, lo_we, wdata MTHI / MTLO write port (idle only)
//   hi, lo              architectural HI / LO
//   busy                state != IDLE
//   done                one-cycle pulse when new HI/LO first visible
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_EX,
    input  logic [1:0]       op_EX,
    input  logic [WIDTH-1:0] dr1_EX,
    input  logic [WIDTH-1:0] dr2_EX,
    input  logic             flush_EX,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_e        state;
    md_state_e        state_next;
    logic [CNT_W-1:0] cnt;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    logic               op_signed;
    logic               op_div;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               take_start;

    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;

    // Magnitude of a possibly signed operand; the most negative value maps to itself,
    // which is also its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        logic [WIDTH-1:0] r;
        r = v;
        if (is_signed && (v < 0)) r = -r;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        logic [WIDTH-1:0] r;
        r = v;
        if (neg) r = -r;
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_2w(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
        logic [2*WIDTH-1:0] r;
        r = v;
        if (neg) r = -r;
        return r;
    endfunction

    assign op_signed  = ~op_EX[0];
    assign op_div     = op_EX[1];
    assign mag1       = magnitude(dr1_EX, op_signed);
    assign mag2       = magnitude(dr2_EX, op_signed);
    assign take_start = (state == IDLE) && start_EX && !flush_EX;

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc),
        .operand   (opnd),
        .op_is_div (is_div),
        .acc_next  (step_acc),
        .q_bit     (step_q)
    );

    // Control: state register, iteration counter, done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == FIXUP) && !flush_EX;
            if (state == CALC) cnt <= cnt + CNT_W'(1);
            else               cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (take_start) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_next = op_div ? CALC : FIXUP;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (flush_EX)             state_next = IDLE;
                else if (cnt == CNT_LAST) state_next = FIXUP;
            end
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch and iteration accumulator
    always_ff @(posedge clk) begin
        if (take_start) begin
            is_div <= op_div;
            neg_q  <= op_signed & (dr1_EX[WIDTH-1] ^ dr2_EX[WIDTH-1]);
            neg_r  <= op_signed & dr1_EX[WIDTH-1];
            div0   <= (dr2_EX == '0);
            if (op_div) begin
                acc  <= {{WIDTH{1'b0}}, mag1};
                opnd <= mag2;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
                acc  <= {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
`else
                acc  <= {{WIDTH{1'b0}}, mag2};
`endif
                opnd <= mag1;
            end
        end else if (state == CALC) begin
            acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
        end
    end

    // Architectural HI/LO: fix-up result or MTHI/MTLO
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == IDLE) begin
            if (!start_EX) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end else if ((state == FIXUP) && !flush_EX) begin
            if (is_div) begin
                hi <= apply_sign(acc[2*WIDTH-1:WIDTH], neg_r);
                lo <= div0 ? DIV0_LO[WIDTH-1:0] : apply_sign(acc[WIDTH-1:0], neg_q);
            end else begin
                {hi, lo} <= apply_sign_2w(acc, neg_q);
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (WIDTH=32).
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_EX;
    logic [1:0]  op_EX;
    logic [31:0] dr1_EX;
    logic [31:0] dr2_EX;
    logic        flush_EX;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_EX (start_EX),
        .op_EX    (op_EX),
        .dr1_EX   (dr1_EX),
        .dr2_EX   (dr2_EX),
        .flush_EX (flush_EX),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns the cycle stamp of the sampling edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int t0);
        @(negedge clk);
        op_EX = op; dr1_EX = a; dr2_EX = b; start_EX = 1'b1;
        tick();
        start_EX = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        t0 = cyc;
    endtask

    // Wait (bounded) for done; returns edges elapsed since the start edge.
    task automatic wait_done(input int t0, output int lat);
        while (!done && (cyc - t0) < 200) tick();
        lat = cyc - t0;
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        @(negedge clk);
        hi_we = hw; lo_we = lw; wdata = d;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int t0;
        int gap;
        issue(op, a, b, t0);
        gap = 0;
        while (!done && (cyc - t0) < 200) begin
            if (!busy) gap++;
            tick();
        end
        check({tag, "_lat"}, cyc - t0, exp_lat);
        check({tag, "_busygap"}, gap, 0);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        tick();
        check({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int t0;
        int lat;
        int dcnt;
        reset = 1'b1; start_EX = 1'b0; op_EX = '0; dr1_EX = '0; dr2_EX = '0;
        flush_EX = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) tick();
        @(negedge clk); reset = 1'b0;
        tick();
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);

        run_op("multu_ff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_m3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("mult_min2", OP_MULT, 32'h80000000, 32'h80000000, MUL_LAT, 32'h40000000, 32'h0);
        run_op("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h0, 32'h80000000);
        run_op("divu_5d0", OP_DIVU, 32'd5, 32'd0, DIV_LAT, 32'd5, 32'hFFFFFFFF);
        run_op("div_m5d0", OP_DIV, 32'hFFFFFFFB, 32'd0, DIV_LAT, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // MTHI / MTLO then flush mid-divide
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        issue(OP_DIVU, 32'd100, 32'd7, t0);
        repeat (9) tick();
        @(negedge clk); flush_EX = 1'b1;
        tick();
        flush_EX = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);
        dcnt = 0;
        repeat (40) begin
            if (done) dcnt++;
            tick();
        end
        check("flush_no_done", dcnt, 0);

        // Reset mid-divide
        issue(OP_DIVU, 32'd100, 32'd7, t0);
        repeat (9) tick();
        @(negedge clk); reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            if (done) dcnt++;
            tick();
        end
        check("midrst_no_done", dcnt, 0);

        // MTLO in the same idle cycle as a start: start wins, LO not written
        mt(1'b0, 1'b1, 32'h99);
        @(negedge clk);
        op_EX = OP_MULTU; dr1_EX = 32'd6; dr2_EX = 32'd7; start_EX = 1'b1;
        lo_we = 1'b1; wdata = 32'hABCD;
        tick();
        start_EX = 1'b0; lo_we = 1'b0;
        t0 = cyc;
        check("coll_lo_kept", lo, 32'h99);
        check("coll_busy", {31'b0, busy}, 32'd1);
        wait_done(t0, lat);
        check("coll_lat", lat, MUL_LAT);
        check("coll_lo", lo, 32'd42);
        check("coll_hi", hi, 32'd0);

        // start_EX and MTHI while busy are both ignored
        issue(OP_DIVU, 32'd100, 32'd7, t0);
        repeat (4) tick();
        @(negedge clk);
        op_EX = OP_MULTU; dr1_EX = 32'd3; dr2_EX = 32'd3; start_EX = 1'b1;
        tick();
        start_EX = 1'b0;
        repeat (3) tick();
        @(negedge clk); hi_we = 1'b1; wdata = 32'hDEAD;
        tick();
        hi_we = 1'b0;
        check("busy_mthi_hi", hi, 32'd0);
        wait_done(t0, lat);
        check("busy_lat", lat, DIV_LAT);
        check("busy_lo", lo, 32'd14);
        check("busy_hi", hi, 32'd2);
        tick();
        dcnt = 0;
        repeat (40) begin
            if (done) dcnt++;
            tick();
        end
        check("busy_no_2nd_done", dcnt, 0);
        check("busy_idle_end", {31'b0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
